// File: rtl/ram_frame_loader_pkg.sv
// Shared types and constants for the framed-byte RAM loader.
// Imported by the loader top and its timeout helper.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_LEN,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         LEN_ZERO_MEANS    = 256;

    // A length byte of zero encodes the maximum frame of 256 words.
    function automatic logic [8:0] len_to_words(input logic [7:0] len);
        return (len == 8'd0) ? 9'(LEN_ZERO_MEANS) : {1'b0, len};
    endfunction

endpackage

// File: rtl/ram_frame_loader_if.sv
// Byte-stream input and RAM write-port output bundle of the frame loader.
// master = loader side, slave = host/RAM side.
interface ram_frame_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  hold_cpu;
    logic                  frame_done;
    logic                  frame_error;
    logic [8:0]            words_written;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data,
        output hold_cpu, frame_done, frame_error, words_written
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data,
        input  hold_cpu, frame_done, frame_error, words_written
    );
endinterface

// File: rtl/ram_frame_loader_timeout.sv
// Inter-byte idle counter: clears on clear or when disabled, flags expiry
// after TIMEOUT_CYCLES-1 idle cycles.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/ram_frame_loader.sv
// Parses SYNC/ADDR/LEN/data/CHK frames from a byte stream and streams 16-bit
// words into the RAM write port, one cycle after each low byte is accepted.
module ram_frame_loader
    import loader_pkg::*;
#(
    parameter int         DATA_WIDTH     = 16,
    parameter int         ADDR_WIDTH     = 9,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               CLK_50,
    input  logic               reset,
    ram_frame_loader_if.master bus
);
    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            hi_q, hi_d;
    logic [8:0]            rem_q, rem_d;
    logic [7:0]            chk_q, chk_d;
    logic [8:0]            ww_q, ww_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic                  tmo_expired;

    // The only stall is the write cycle, so the RAM port is never contended.
    assign accept = bus.byte_valid && !wr_en_q;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK_50),
        .reset  (reset),
        .clear  (accept),
        .enable (state_q != ST_IDLE),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hi_d      = hi_q;
        rem_d     = rem_q;
        chk_d     = chk_q;
        ww_d      = ww_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (tmo_expired) begin
            // Any half-built word is simply dropped.
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.byte_in == SYNC_BYTE) begin
                        state_d = ST_ADDR_HI;
                        chk_d   = 8'h00;
                        ww_d    = 9'd0;
                    end
                end
                ST_ADDR_HI: begin
                    hi_d    = bus.byte_in;
                    chk_d   = chk_q ^ bus.byte_in;
                    state_d = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    addr_d  = ADDR_WIDTH'({hi_q, bus.byte_in});
                    chk_d   = chk_q ^ bus.byte_in;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    rem_d   = len_to_words(bus.byte_in);
                    chk_d   = chk_q ^ bus.byte_in;
                    state_d = ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    hi_d    = bus.byte_in;
                    chk_d   = chk_q ^ bus.byte_in;
                    state_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = DATA_WIDTH'({hi_q, bus.byte_in});
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    ww_d      = ww_q + 9'd1;
                    rem_d     = rem_q - 9'd1;
                    chk_d     = chk_q ^ bus.byte_in;
                    state_d   = (rem_q == 9'd1) ? ST_CHECK : ST_DATA_HI;
                end
                ST_CHECK: begin
                    done_d  = (bus.byte_in == chk_q);
                    err_d   = (bus.byte_in != chk_q);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            hi_q      <= 8'h00;
            rem_q     <= 9'd0;
            chk_q     <= 8'h00;
            ww_q      <= 9'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            rem_q     <= rem_d;
            chk_q     <= chk_d;
            ww_q      <= ww_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.byte_ready    = !wr_en_q;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data       = wr_data_q;
    assign bus.hold_cpu      = (state_q != ST_IDLE);
    assign bus.frame_done    = done_q;
    assign bus.frame_error   = err_q;
    assign bus.words_written = ww_q;

endmodule

// File: tb/tb_ram_frame_loader.sv
// Directed bench for ram_frame_loader: table of short frames plus hand-written
// sequences for LEN=0, garbage, timeout and mid-frame reset.
module tb_ram_frame_loader;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ram_frame_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) lif ();

    ram_frame_loader #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (9),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK_50(clk),
        .reset (rst),
        .bus   (lif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0]  wa_log[$];
    logic [15:0] wd_log[$];
    int          done_cnt;
    int          err_cnt;
    int          excl_viol;

    initial begin
        done_cnt  = 0;
        err_cnt   = 0;
        excl_viol = 0;
    end

    always @(negedge clk) begin
        if (lif.wr_en) begin
            wa_log.push_back(lif.wr_addr);
            wd_log.push_back(lif.wr_data);
        end
        if (lif.frame_done)  done_cnt++;
        if (lif.frame_error) err_cnt++;
        if (lif.frame_done && lif.frame_error) excl_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns #1 after the edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        lif.byte_in    = b;
        lif.byte_valid = 1'b1;
        while (!lif.byte_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!lif.byte_ready) begin
            errors++;
            checks++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        lif.byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  ahi, alo, len;
        logic [15:0] w0, w1;
        logic [7:0]  chk;
        logic        exp_done, exp_err;
        logic [8:0]  exp_a0, exp_a1;
        logic [8:0]  exp_ww;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int w0i, d0, e0;
        logic [7:0] x;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        lif.byte_in    = 8'h00;
        lif.byte_valid = 1'b0;

        // Checksums hand-computed as XOR of ADDR_HI..last data byte.
        vecs[0] = '{8'h00, 8'h10, 8'h02, 16'h1234, 16'hABCD, 8'h52, 1'b1, 1'b0, 9'h010, 9'h011, 9'd2};
        vecs[1] = '{8'h00, 8'h10, 8'h02, 16'h1234, 16'hABCD, 8'hFF, 1'b0, 1'b1, 9'h010, 9'h011, 9'd2};
        vecs[2] = '{8'h01, 8'hFF, 8'h02, 16'h1111, 16'h2222, 8'hFC, 1'b1, 1'b0, 9'h1FF, 9'h000, 9'd2};
        vecs[3] = '{8'hFE, 8'h05, 8'h01, 16'hA5A5, 16'h0000, 8'hFA, 1'b1, 1'b0, 9'h005, 9'h000, 9'd1};

        idle(3);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_byte_ready", lif.byte_ready, 1);
        check("rst_wr_en", lif.wr_en, 0);
        check("rst_hold", lif.hold_cpu, 0);
        check("rst_done", lif.frame_done, 0);
        check("rst_err", lif.frame_error, 0);
        check("rst_ww", lif.words_written, 0);
        check("rst_wr_addr", lif.wr_addr, 0);
        check("rst_wr_data", lif.wr_data, 0);

        // Garbage in IDLE
        send_byte(8'h00); check("garb0_hold", lif.hold_cpu, 0);
        send_byte(8'hFF); check("garb1_hold", lif.hold_cpu, 0);
        send_byte(8'h5A); check("garb2_hold", lif.hold_cpu, 0);
        idle(2);
        check("garb_writes", wa_log.size(), 0);

        for (int v = 0; v < 4; v++) begin
            w0i = wa_log.size(); d0 = done_cnt; e0 = err_cnt;
            send_byte(8'hA5);
            check("v_hold_sync", lif.hold_cpu, 1);
            send_byte(vecs[v].ahi);
            send_byte(vecs[v].alo);
            send_byte(vecs[v].len);
            send_byte(vecs[v].w0[15:8]);
            send_byte(vecs[v].w0[7:0]);
            if (vecs[v].len == 8'd2) begin
                send_byte(vecs[v].w1[15:8]);
                send_byte(vecs[v].w1[7:0]);
            end
            check("v_hold_before_chk", lif.hold_cpu, 1);
            send_byte(vecs[v].chk);
            check("v_hold_after_chk", lif.hold_cpu, 0);
            check("v_done_pulse", lif.frame_done, vecs[v].exp_done);
            check("v_err_pulse", lif.frame_error, vecs[v].exp_err);
            idle(3);
            check("v_done_cnt", done_cnt - d0, 32'(vecs[v].exp_done));
            check("v_err_cnt", err_cnt - e0, 32'(vecs[v].exp_err));
            check("v_nwrites", wa_log.size() - w0i, 32'(vecs[v].len));
            if (wa_log.size() > w0i) begin
                check("v_a0", wa_log[w0i], vecs[v].exp_a0);
                check("v_d0", wd_log[w0i], vecs[v].w0);
            end
            if (vecs[v].len == 8'd2 && wa_log.size() > w0i + 1) begin
                check("v_a1", wa_log[w0i+1], vecs[v].exp_a1);
                check("v_d1", wd_log[w0i+1], vecs[v].w1);
            end
            check("v_ww", lif.words_written, vecs[v].exp_ww);
        end

        // LEN=0 -> 256 words at 0x100
        w0i = wa_log.size(); d0 = done_cnt;
        x = 8'h01 ^ 8'h00 ^ 8'h00;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            send_byte(~8'(i));
            x = x ^ 8'(i) ^ ~8'(i);
        end
        send_byte(x);
        idle(3);
        check("len0_nwrites", wa_log.size() - w0i, 256);
        check("len0_ww", lif.words_written, 256);
        check("len0_done", done_cnt - d0, 1);
        if (wa_log.size() >= w0i + 256) begin
            check("len0_first_addr", wa_log[w0i], 9'h100);
            check("len0_last_addr", wa_log[w0i+255], 9'h1FF);
            check("len0_last_data", wd_log[w0i+255], 16'hFF00);
        end

        // Timeout after one data byte
        w0i = wa_log.size(); d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20); send_byte(8'h01);
        send_byte(8'h77);
        for (int i = 0; i < 150 && err_cnt == e0; i++) @(negedge clk);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_hold", lif.hold_cpu, 0);
        check("tmo_nwrites", wa_log.size() - w0i, 0);
        send_byte(8'h88);
        idle(3);
        check("tmo_idle_hold", lif.hold_cpu, 0);
        check("tmo_idle_nwrites", wa_log.size() - w0i, 0);
        check("tmo_done", done_cnt - d0, 0);

        // Reset while in DATA_LO with the low byte presented
        w0i = wa_log.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h30); send_byte(8'h01);
        send_byte(8'h12);
        @(negedge clk);
        lif.byte_in = 8'h34; lif.byte_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_wr_en", lif.wr_en, 0);
        check("mrst_hold", lif.hold_cpu, 0);
        check("mrst_ready", lif.byte_ready, 1);
        check("mrst_done", lif.frame_done, 0);
        check("mrst_err", lif.frame_error, 0);
        check("mrst_ww", lif.words_written, 0);
        lif.byte_valid = 1'b0; rst = 1'b0;
        idle(4);
        check("mrst_nwrites", wa_log.size() - w0i, 0);
        check("pulse_exclusive", excl_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
